sfifof_rr_sched: RTL and testbench

Round-robin dequeue scheduler that shares one downstream consumer among NUM_Q flop-based synchronous FIFOs (sfifof instances). It watches each queue's empty flag, issues one-hot pops, and registers the selected head word into a single output stage with a valid/ready handshake. It sits between a bank of per-requester queues and a single shared datapath port.

---
 rtl/sfifof_rr_sched.sv | 135 +++++++++++++
 tb/tb_sfifof_rr_sched.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sfifof_rr_sched.sv
// Round-robin pop scheduler over NUM_Q sfifof queues, one registered output.
// Define SFIFOF_RR_SCHED_BURST_EN for sticky grants of up to BURST_MAX pops.
module sfifof_rr_sched #(
  parameter int WIDTH     = 16,
  parameter int NUM_Q     = 4,
  parameter int QID_BITS  = 2,
  parameter int BURST_MAX = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic [NUM_Q-1:0]       q_empty,
  input  logic [NUM_Q*WIDTH-1:0] q_dout,
  output logic [NUM_Q-1:0]       q_rd,
  output logic [WIDTH-1:0]       out_data,
  output logic [QID_BITS-1:0]    out_qid,
  output logic                   out_valid,
  input  logic                   out_ready
);

  if (NUM_Q < 2 || NUM_Q > 16 ||
      (1 << QID_BITS) < NUM_Q ||
      BURST_MAX < 1 || BURST_MAX > 15) begin : g_bad_cfg
    $error("sfifof_rr_sched: bad parameters");
  end

  logic                last_q_unused;
  logic [QID_BITS-1:0] last_q;
  logic [QID_BITS-1:0] arb_q;
  logic                arb_found;
  logic [QID_BITS-1:0] pop_q;
  logic                pop_v;
  logic                slot_free;
  logic                can_pop;
  logic [WIDTH-1:0]    sel_data;

  assign last_q_unused = 1'b0;
  assign slot_free = !out_valid || out_ready;
  assign can_pop   = rst_n && enable && slot_free;

  // First non-empty queue after the last one granted.
  always_comb begin
    int idx;
    arb_found = 1'b0;
    arb_q     = '0;
    idx       = 0;
    for (int k = 1; k <= NUM_Q; k++) begin
      idx = (int'(last_q) + k) % NUM_Q;
      if (!arb_found && !q_empty[idx]) begin
        arb_found = 1'b1;
        arb_q     = QID_BITS'(idx);
      end
    end
  end

`ifdef SFIFOF_RR_SCHED_BURST_EN
  typedef enum logic {
    IDLE,
    HOLD
  } state_t;

  state_t     state;
  logic [3:0] burst_cnt;
  logic       hold_ok;

  assign hold_ok = (state == HOLD) &&
                   !q_empty[last_q] &&
                   enable &&
                   (burst_cnt < 4'(BURST_MAX - 1));

  always_comb begin
    pop_v = 1'b0;
    pop_q = arb_q;
    if (can_pop) begin
      unique case (1'b1)
        hold_ok: begin
          pop_v = 1'b1;
          pop_q = last_q;
        end
        arb_found: begin
          pop_v = 1'b1;
          pop_q = arb_q;
        end
        default: pop_v = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      burst_cnt <= '0;
    end else if (slot_free) begin
      if (pop_v) begin
        state     <= HOLD;
        burst_cnt <= hold_ok ? burst_cnt + 4'd1 : 4'd0;
      end else begin
        state     <= IDLE;
        burst_cnt <= '0;
      end
    end
  end
`else
  assign pop_v = can_pop && arb_found;
  assign pop_q = arb_q;
`endif

  assign q_rd = pop_v ? (NUM_Q'(1) << pop_q) : '0;

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_Q; i++) begin
      if (pop_q == QID_BITS'(i)) begin
        sel_data = q_dout[i*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_qid   <= '0;
      out_valid <= 1'b0;
      last_q    <= QID_BITS'(NUM_Q - 1);
    end else if (pop_v) begin
      out_data  <= sel_data;
      out_qid   <= pop_q;
      out_valid <= 1'b1;
      last_q    <= pop_q;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sfifof_rr_sched.sv
// Scoreboard bench for sfifof_rr_sched with behavioural sfifof queues.
// Burst sequence is checked when SFIFOF_RR_SCHED_BURST_EN is defined.
module tb_sfifof_rr_sched;

  localparam int W  = 16;
  localparam int NQ = 4;
  localparam int QB = 2;

  typedef struct {
    logic [QB-1:0] qid;
    logic [W-1:0]  data;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            enable;
  logic [NQ-1:0]   q_empty;
  logic [NQ*W-1:0] q_dout;
  logic [NQ-1:0]   q_rd;
  logic [W-1:0]    out_data;
  logic [QB-1:0]   out_qid;
  logic            out_valid;
  logic            out_ready;

  logic [W-1:0]    fifo [NQ][$];
  exp_t            exp_q [$];
  logic [NQ-1:0]   rd_s;
  int              n_cmp = 0;
  int              n_bad = 0;

  sfifof_rr_sched #(
    .WIDTH(W), .NUM_Q(NQ), .QID_BITS(QB), .BURST_MAX(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .q_empty(q_empty), .q_dout(q_dout), .q_rd(q_rd),
    .out_data(out_data), .out_qid(out_qid),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] mk(int q, int t, int k);
    return {4'(q), 4'(t), 8'(k)};
  endfunction

  task automatic check(string nm, logic [31:0] act, logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic refresh();
    for (int i = 0; i < NQ; i++) begin
      q_empty[i] = (fifo[i].size() == 0);
      q_dout[i*W +: W] = (fifo[i].size() != 0) ? fifo[i][0] : '0;
    end
  endtask

  task automatic push(int q, logic [W-1:0] d);
    fifo[q].push_back(d);
    refresh();
  endtask

  task automatic expect_word(int q, logic [W-1:0] d);
    exp_t e;
    e.qid  = QB'(q);
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_drain(string nm);
    int c = 0;
    while ((exp_q.size() != 0 || out_valid) && c < 60) begin
      @(negedge clk);
      c++;
    end
    check(nm, 32'(c < 60), 32'd1);
    step();
  endtask

  // sfifof behaviour: pop on the edge after q_rd seen.
  always @(negedge clk) rd_s = q_rd;

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < NQ; i++) begin
      if (rd_s[i] && fifo[i].size() != 0) begin
        void'(fifo[i].pop_front());
      end
    end
    rd_s = '0;
    refresh();
  end

  // Monitor: handshake scoreboard plus pop legality.
  always @(negedge clk) begin
    if (rst_n) begin
      logic legal;
      logic busy;
      legal = $onehot0(q_rd) && ((q_rd & q_empty) == '0) &&
              (q_rd == '0 || (enable && (!out_valid || out_ready)));
      check("rd_legal", 32'(legal), 32'd1);
      busy = enable && (q_empty != '1) && (!out_valid || out_ready);
      check("rd_work", 32'(q_rd != '0), 32'(busy));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", {16'(out_qid), out_data}, 32'hffff_ffff);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("out_qid", 32'(out_qid), 32'(e.qid));
          check("out_data", 32'(out_data), 32'(e.data));
        end
      end
    end
  end

  initial begin
    int bseq [12];
    int bk [2];
    rst_n     = 1'b0;
    enable    = 1'b1;
    out_ready = 1'b1;
    rd_s      = '0;
    refresh();

    // Reset state.
    repeat (3) step();
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_rd", 32'(q_rd), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    check("rst_qid", 32'(out_qid), 32'd0);
    rst_n = 1'b1;

    // Idle with all queues empty.
    repeat (20) begin
      @(negedge clk);
      check("idle_rd", 32'(q_rd), 32'd0);
      check("idle_valid", 32'(out_valid), 32'd0);
    end
    step();

    // All queues loaded: 0,1,2,3,0,1,2,3 at full rate.
    for (int k = 0; k < 2; k++) begin
      for (int q = 0; q < NQ; q++) begin
        push(q, mk(q, 2, k));
        expect_word(q, mk(q, 2, k));
      end
    end
    @(negedge clk);
    check("rr_first_rd", 32'(q_rd), 32'h1);
    repeat (8) begin
      @(negedge clk);
      check("rr_rate", 32'(out_valid), 32'd1);
    end
    @(negedge clk);
    check("rr_done", 32'(out_valid), 32'd0);
    wait_drain("rr_drain");

    // Only queue 2 holds three words.
    for (int k = 0; k < 3; k++) begin
      push(2, mk(2, 3, k));
      expect_word(2, mk(2, 3, k));
    end
    @(negedge clk);
    check("q2_rd", 32'(q_rd), 32'h4);
    repeat (3) begin
      @(negedge clk);
      check("q2_valid", 32'(out_valid), 32'd1);
    end
    @(negedge clk);
    check("q2_done", 32'(out_valid), 32'd0);
    wait_drain("q2_drain");

    // Backpressure: first word held for 5 cycles.
    out_ready = 1'b0;
    for (int q = 0; q < 3; q++) begin
      push(q, mk(q, 4, q));
      expect_word(q, mk(q, 4, q));
    end
    @(negedge clk);
    repeat (5) begin
      @(negedge clk);
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_rd", 32'(q_rd), 32'd0);
      check("bp_qid", 32'(out_qid), 32'd0);
      check("bp_data", 32'(out_data), 32'(mk(0, 4, 0)));
    end
    step();
    out_ready = 1'b1;
    wait_drain("bp_drain");

`ifdef SFIFOF_RR_SCHED_BURST_EN
    // Sticky grants of 4 pops.
    bseq = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 1, 1};
    bk   = '{0, 0};
    for (int k = 0; k < 6; k++) begin
      push(0, mk(0, 7, k));
      push(1, mk(1, 7, k));
    end
    for (int i = 0; i < 12; i++) begin
      expect_word(bseq[i], mk(bseq[i], 7, bk[bseq[i]]));
      bk[bseq[i]]++;
    end
    wait_drain("burst_drain");
`else
    bseq = '{default: 0};
    bk   = '{default: 0};
`endif

    // Enable low blocks pops.
    enable = 1'b0;
    push(0, mk(0, 6, 0));
    expect_word(0, mk(0, 6, 0));
    repeat (3) begin
      @(negedge clk);
      check("en_rd", 32'(q_rd), 32'd0);
      check("en_valid", 32'(out_valid), 32'd0);
    end
    step();
    enable = 1'b1;
    wait_drain("en_drain");

    // Reset while queue 3 word sits in the output stage.
    out_ready = 1'b0;
    push(3, mk(3, 5, 0));
    step();
    push(1, mk(1, 5, 1));
    push(2, mk(2, 5, 2));
    push(3, mk(3, 5, 3));
    @(negedge clk);
    check("mid_valid", 32'(out_valid), 32'd1);
    check("mid_qid", 32'(out_qid), 32'd3);
    step();
    rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_data", 32'(out_data), 32'd0);
    check("arst_rd", 32'(q_rd), 32'd0);
    step();
    expect_word(1, mk(1, 5, 1));
    expect_word(2, mk(2, 5, 2));
    expect_word(3, mk(3, 5, 3));
    rst_n     = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check("post_rst_rd", 32'(q_rd), 32'h2);
    wait_drain("post_rst_drain");

    check("sb_empty", 32'(exp_q.size()), 32'd0);
    for (int q = 0; q < NQ; q++) begin
      check("fifo_empty", 32'(fifo[q].size()), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
